// File: rtl/keypad_pkg.sv
// Shared constants and types for the keypad debouncer: register map, channel FSM states
// and the layout of the last-key register.
package keypad_pkg;

  localparam logic [1:0] AddrStatus = 2'd0;
  localparam logic [1:0] AddrEvents = 2'd1;
  localparam logic [1:0] AddrMask   = 2'd2;
  localparam logic [1:0] AddrLast   = 2'd3;

  localparam int unsigned LastValidBit = 7;
  localparam int unsigned LastIdxW     = 3;

  typedef enum logic [1:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait
  } deb_state_e;

  // Converts a raw synchronized pin level into "pressed" polarity.
  function automatic logic is_pressed(logic raw, bit active_low);
    return raw ^ active_low;
  endfunction

endpackage

// File: rtl/deb_channel.sv
// One pushbutton channel: 2-flop synchronizer, debounce counter and press/release FSM.
// Optional auto-repeat timer is built when KEYPAD_DEBOUNCE_REPEAT_EN is defined.
module deb_channel
  import keypad_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned CNT_W      = 16,
  parameter bit          ACTIVE_LOW = 1'b1
`ifdef KEYPAD_DEBOUNCE_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = 500000,
  parameter int unsigned REPEAT_PERIOD = 100000
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pb_i,
  output logic level_o,
  output logic press_o
);

  localparam logic SyncIdle = ACTIVE_LOW;
  // The sample that leaves the idle state counts as the first of DEB_CYCLES.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_CYCLES - 2);

  logic [1:0]       sync_q;
  logic             sample;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             rpt_fire;

  assign sample = is_pressed(sync_q[1], ACTIVE_LOW);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    accept  = 1'b0;
    unique case (state_q)
      StReleased: begin
        if (sample) state_d = StPressWait;
      end
      StPressWait: begin
        if (!sample) begin
          state_d = StReleased;
        end else if (cnt_q == CntLast) begin
          state_d = StPressed;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StPressed: begin
        if (!sample) state_d = StReleaseWait;
      end
      StReleaseWait: begin
        if (sample) begin
          state_d = StPressed;
        end else if (cnt_q == CntLast) begin
          state_d = StReleased;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StReleased;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= {2{SyncIdle}};
      state_q <= StReleased;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], pb_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef KEYPAD_DEBOUNCE_REPEAT_EN
  localparam int unsigned RptMax =
      (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW = $clog2(RptMax + 1);
  localparam logic [RptW-1:0] DelayLast  = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] PeriodLast = RptW'(REPEAT_PERIOD - 1);

  logic [RptW-1:0] rpt_q, rpt_d;
  logic            rpt_first_q, rpt_first_d;

  // Timer runs only while the key stays in StPressed; any exit rearms the initial delay.
  always_comb begin
    rpt_d       = '0;
    rpt_first_d = 1'b1;
    rpt_fire    = 1'b0;
    if (state_q == StPressed && state_d == StPressed) begin
      rpt_first_d = rpt_first_q;
      if (rpt_q == (rpt_first_q ? DelayLast : PeriodLast)) begin
        rpt_fire    = 1'b1;
        rpt_first_d = 1'b0;
      end else begin
        rpt_d = rpt_q + RptW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign level_o = (state_q == StPressed) || (state_q == StReleaseWait);
  assign press_o = accept | rpt_fire;

endmodule

// File: rtl/keypad_debounce.sv
// Multi-key debouncer with a 4-entry register file (status, sticky events, mask, last key).
// Defining KEYPAD_DEBOUNCE_REPEAT_EN adds auto-repeat of held keys.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned N_KEYS     = 5,
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned CNT_W      = 16,
  parameter bit          ACTIVE_LOW = 1'b1
`ifdef KEYPAD_DEBOUNCE_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = 500000,
  parameter int unsigned REPEAT_PERIOD = 100000
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] pb,
  input  logic [1:0]        addr,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              irq,
  output logic              led
);

  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    deb_channel #(
      .DEB_CYCLES    (DEB_CYCLES),
      .CNT_W         (CNT_W),
      .ACTIVE_LOW    (ACTIVE_LOW)
`ifdef KEYPAD_DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_chan (
      .clk_i   (clk),
      .rst_i   (reset),
      .pb_i    (pb[i]),
      .level_o (level[i]),
      .press_o (press[i])
    );
  end

  logic [N_KEYS-1:0]   events_q, events_d;
  logic [N_KEYS-1:0]   mask_q, mask_d;
  logic [N_KEYS-1:0]   wr_bits, clr_bits;
  logic                last_valid_q, last_valid_d;
  logic [LastIdxW-1:0] last_idx_q, last_idx_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                irq_q;
  logic                wr_events, wr_mask, wr_last;
  logic                unused_wdata;

  assign wr_bits      = wdata[N_KEYS-1:0];
  assign unused_wdata = ^wdata;
  assign wr_events    = wr_en && (addr == AddrEvents);
  assign wr_mask      = wr_en && (addr == AddrMask);
  assign wr_last      = wr_en && (addr == AddrLast);
  assign clr_bits     = wr_events ? wr_bits : '0;

  always_comb begin
    // New presses are OR-ed in after the clear so a same-cycle set survives.
    events_d     = (events_q & ~clr_bits) | press;
    mask_d       = wr_mask ? wr_bits : mask_q;
    last_valid_d = last_valid_q & ~wr_last;
    last_idx_d   = last_idx_q;
    // Descending scan leaves the lowest simultaneous index as the winner.
    for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
      if (press[i]) begin
        last_valid_d = 1'b1;
        last_idx_d   = LastIdxW'(i);
      end
    end
  end

  // Reads use pre-write register values so a same-cycle write is not visible yet.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      unique case (addr)
        AddrStatus: rdata_d = 8'(level);
        AddrEvents: rdata_d = 8'(events_q);
        AddrMask:   rdata_d = 8'(mask_q);
        AddrLast: begin
          rdata_d[LastValidBit]    = last_valid_q;
          rdata_d[LastIdxW-1:0]    = last_idx_q;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      events_q     <= '0;
      mask_q       <= '0;
      last_valid_q <= 1'b0;
      last_idx_q   <= '0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      events_q     <= events_d;
      mask_q       <= mask_d;
      last_valid_q <= last_valid_d;
      last_idx_q   <= last_idx_d;
      rdata_q      <= rdata_d;
      irq_q        <= |(events_q & mask_q);
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;
  assign led   = |level;

endmodule

// File: tb/tb_keypad_debounce.sv
// Self-checking bench for keypad_debounce with DEB_CYCLES=4, N_KEYS=5, active-low keys.
`timescale 1ns/1ps
module tb_keypad_debounce;

  localparam int unsigned NK = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] pb;
  logic [1:0]    addr;
  logic          rd_en;
  logic          wr_en;
  logic [7:0]    wdata;
  logic [7:0]    rdata;
  logic          irq;
  logic          led;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] a;
    logic [7:0] v;
    logic [7:0] m;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;

  keypad_debounce #(
    .N_KEYS        (NK),
    .DEB_CYCLES    (4),
    .CNT_W         (8),
    .ACTIVE_LOW    (1'b1)
`ifdef KEYPAD_DEBOUNCE_REPEAT_EN
    ,
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pb    (pb),
    .addr  (addr),
    .rd_en (rd_en),
    .wr_en (wr_en),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq),
    .led   (led)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every read strobe pops one expectation when rdata lands.
  always @(posedge clk) begin
    if (rd_en) begin
      #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: read of addr %0d returned %h with nothing expected",
                 addr, rdata);
      end else begin
        got_e = sb.pop_front();
        if ((rdata & got_e.m) !== (got_e.v & got_e.m)) begin
          errors++;
          $display("FAIL %s: addr %0d rdata=%h expected %h (mask %h)",
                   got_e.name, got_e.a, rdata, got_e.v, got_e.m);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic rd_exp(input logic [1:0] a, input logic [7:0] v, input logic [7:0] m,
                        input string name);
    exp_t e;
    e.a = a; e.v = v; e.m = m; e.name = name;
    sb.push_back(e);
    addr = a; rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic clear_regs();
    wr(2'd1, 8'hFF);
    wr(2'd3, 8'h00);
    wr(2'd2, 8'h00);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    checks++;
    if ({rdata, irq, led} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdata=%h irq=%b led=%b expected 00/0/0", rdata, irq, led);
    end
    reset = 1'b0;
    tick(1);
    rd_exp(2'd0, 8'h00, 8'hFF, "reset_status");
    rd_exp(2'd1, 8'h00, 8'hFF, "reset_events");
    rd_exp(2'd2, 8'h00, 8'hFF, "reset_mask");
    rd_exp(2'd3, 8'h00, 8'hFF, "reset_last");
  endtask

  task automatic test_reset_mid();
    wr(2'd2, 8'h15);
    rd_exp(2'd2, 8'h15, 8'hFF, "mask_readback");
    pb[0] = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_clears_rdata: rdata=%h expected 00", rdata);
    end
    tick(5);
    checks++;
    if (led !== 1'b0) begin
      errors++;
      $display("FAIL reset_partial_discarded: led=%b expected 0", led);
    end
    tick(1);
    checks++;
    if (led !== 1'b1) begin
      errors++;
      $display("FAIL reset_requalified: led=%b expected 1", led);
    end
    rd_exp(2'd2, 8'h00, 8'hFF, "reset_mid_mask");
    rd_exp(2'd1, 8'h01, 8'hFF, "reset_mid_events");
    pb = '1;
    tick(8);
  endtask

  task automatic test_press();
    clear_regs();
    pb[2] = 1'b0;
    tick(5);
    checks++;
    if (led !== 1'b0) begin
      errors++;
      $display("FAIL press_too_early: led=%b expected 0", led);
    end
    tick(1);
    checks++;
    if (led !== 1'b1) begin
      errors++;
      $display("FAIL press_led: led=%b expected 1", led);
    end
    rd_exp(2'd0, 8'h04, 8'hFF, "press_status");
    rd_exp(2'd1, 8'h04, 8'hFF, "press_events");
    rd_exp(2'd3, 8'h82, 8'hFF, "press_last");
    wr(2'd2, 8'h00);
    checks++;
    if (rdata !== 8'h82) begin
      errors++;
      $display("FAIL rdata_hold: rdata=%h expected 82", rdata);
    end
    pb[2] = 1'b1;
    tick(5);
    checks++;
    if (led !== 1'b1) begin
      errors++;
      $display("FAIL release_too_early: led=%b expected 1", led);
    end
    tick(1);
    checks++;
    if (led !== 1'b0) begin
      errors++;
      $display("FAIL release_led: led=%b expected 0", led);
    end
    rd_exp(2'd0, 8'h00, 8'hFF, "release_status");
  endtask

  task automatic test_bounce();
    clear_regs();
    wr(2'd2, 8'h1F);
    pb[0] = 1'b0;
    tick(3);
    pb[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      checks++;
      if ({irq, led} !== 2'b00) begin
        errors++;
        $display("FAIL bounce_quiet: cycle %0d irq=%b led=%b expected 0/0", k, irq, led);
      end
    end
    rd_exp(2'd0, 8'h00, 8'hFF, "bounce_status");
    rd_exp(2'd1, 8'h00, 8'hFF, "bounce_events");
  endtask

  task automatic test_mask_irq();
    clear_regs();
    wr(2'd2, 8'h01);
    pb[1] = 1'b0;
    tick(8);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL mask_blocks_irq: irq=%b expected 0", irq);
    end
    rd_exp(2'd1, 8'h02, 8'hFF, "masked_events");
    pb[0] = 1'b0;
    tick(6);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_latency: irq=%b expected 0 on event cycle", irq);
    end
    tick(1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: irq=%b expected 1", irq);
    end
    wr(2'd1, 8'h01);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_hold: irq=%b expected 1 on clear cycle", irq);
    end
    tick(1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: irq=%b expected 0", irq);
    end
    pb = '1;
    tick(8);
  endtask

  task automatic test_rw_collision();
    clear_regs();
    wr(2'd2, 8'h01);
    sb.push_back('{a: 2'd2, v: 8'h01, m: 8'hFF, name: "rw_pre_write"});
    addr = 2'd2; wdata = 8'hFF; rd_en = 1'b1; wr_en = 1'b1;
    tick(1);
    rd_en = 1'b0; wr_en = 1'b0;
    rd_exp(2'd2, 8'h1F, 8'hFF, "mask_upper_ignored");
  endtask

  task automatic test_simultaneous();
    clear_regs();
    pb[3] = 1'b0;
    pb[1] = 1'b0;
    tick(8);
    rd_exp(2'd0, 8'h0A, 8'hFF, "simul_status");
    rd_exp(2'd1, 8'h0A, 8'hFF, "simul_events");
    rd_exp(2'd3, 8'h81, 8'hFF, "simul_last");
    wr(2'd3, 8'h00);
    rd_exp(2'd3, 8'h00, 8'h80, "last_valid_clear");
    pb = '1;
    tick(8);
  endtask

  task automatic test_back_to_back_w1c();
    clear_regs();
    pb[4] = 1'b0;
    tick(5);
    wr(2'd1, 8'h10);
    rd_exp(2'd1, 8'h10, 8'hFF, "w1c_vs_set");
    wr(2'd1, 8'h10);
    rd_exp(2'd1, 8'h00, 8'hFF, "w1c_clears");
    pb = '1;
    tick(8);
  endtask

  // Clear events every cycle; with set-wins, irq one cycle later marks each re-set.
  task automatic test_repeat();
    logic exp_irq;
    clear_regs();
    wr(2'd2, 8'h04);
    pb[2] = 1'b0;
    tick(6);
    addr = 2'd1; wdata = 8'h04; wr_en = 1'b1;
    tick(1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL repeat_accept_irq: irq=%b expected 1", irq);
    end
    for (int k = 2; k <= 18; k++) begin
      tick(1);
`ifdef KEYPAD_DEBOUNCE_REPEAT_EN
      exp_irq = ((k - 1) == 8) || ((k - 1) == 12) || ((k - 1) == 16);
`else
      exp_irq = 1'b0;
`endif
      checks++;
      if (irq !== exp_irq) begin
        errors++;
        $display("FAIL repeat_event: +%0d irq=%b expected %b", k - 1, irq, exp_irq);
      end
    end
    wr_en = 1'b0;
    pb = '1;
    tick(10);
  endtask

  initial begin
    reset = 1'b1;
    pb    = '1;
    addr  = 2'd0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    wdata = 8'h00;
    test_reset();
    test_reset_mid();
    test_press();
    test_bounce();
    test_mask_irq();
    test_rw_collision();
    test_simultaneous();
    test_back_to_back_w1c();
    test_repeat();
    tick(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d reads expected but not seen, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
